wdma_row_scheduler: RTL and testbench

WDMA_ROW_SCHEDULER -- requirements
Module: wdma_row_scheduler

---
 rtl/wdma_row_scheduler_if.sv | 35 +++
 rtl/wdma_row_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_wdma_row_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wdma_row_scheduler_if.sv
// ---------------------------------------------------------------------------
// wdma_row_scheduler_if
// Handshake bundle between the row scheduler and a write DMA engine.
//   dma_start_addr      : DDR byte address of the row being written
//   dma_transfer_length : row length in bytes
//   dma_start           : level request, held until the DMA reports done
//   dma_done            : DMA completion level, held while dma_start is high
//   dma_error           : DMA error flag, valid together with dma_done
// master = scheduler side, slave = DMA side.
// ---------------------------------------------------------------------------
interface wdma_row_scheduler_if #(
    parameter int AXI_ADDR_WIDTH = 64
);
    logic [AXI_ADDR_WIDTH-1:0] dma_start_addr;
    logic [31:0]               dma_transfer_length;
    logic                      dma_start;
    logic                      dma_done;
    logic                      dma_error;

    modport master (
        output dma_start_addr,
        output dma_transfer_length,
        output dma_start,
        input  dma_done,
        input  dma_error
    );

    modport slave (
        input  dma_start_addr,
        input  dma_transfer_length,
        input  dma_start,
        output dma_done,
        output dma_error
    );
endinterface

// File: rtl/wdma_row_scheduler.sv
// ---------------------------------------------------------------------------
// wdma_row_scheduler
// Splits a 2-D write job (num_rows rows of row_bytes each, rows row_stride
// bytes apart starting at base_addr) into one write-DMA transfer per row,
// issued strictly one after another.
// Ports:
//   aclk, aresetn         : clock, asynchronous active-low reset
//   cfg_base_addr/num_rows/row_bytes/row_stride : job description
//   cfg_start             : job start, only honoured when idle
//   busy                  : high from job accept until the done pulse
//   done                  : one-cycle job-complete pulse
//   error                 : sticky job error, cleared on the next accept
//   rows_done             : rows completed in the current job
//   dma                   : write-DMA handshake (master side)
// ---------------------------------------------------------------------------
module wdma_row_scheduler #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int BEAT_BYTES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [15:0]               cfg_num_rows,
    input  logic [31:0]               cfg_row_bytes,
    input  logic [31:0]               cfg_row_stride,
    input  logic                      cfg_start,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [15:0]               rows_done,
    wdma_row_scheduler_if.master      dma
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RELEASE,
        S_FINISH
    } state_t;

    localparam logic [31:0] BEAT_BYTES_W = 32'(BEAT_BYTES);
    localparam logic [31:0] WD_LAST      = 32'(TIMEOUT_CYCLES - 1);
    localparam bit          WD_ENABLE    = (TIMEOUT_CYCLES != 0);

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [AXI_ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
    logic [31:0]               xfer_len_q, xfer_len_d;
    logic [31:0]               row_bytes_q, row_bytes_d;
    logic [31:0]               row_stride_q, row_stride_d;
    logic [31:0]               wd_cnt_q, wd_cnt_d;
    logic [15:0]               num_rows_q, num_rows_d;
    logic [15:0]               rows_done_q, rows_done_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;
    logic                      dma_start_q, dma_start_d;
    logic                      abort_q, abort_d;
    logic                      row_len_bad;

    // Checked on the latched copy, one cycle after accept.
    assign row_len_bad = (row_bytes_q == 32'd0) ||
                         ((row_bytes_q % BEAT_BYTES_W) != 32'd0);

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        start_addr_d = start_addr_q;
        xfer_len_d   = xfer_len_q;
        row_bytes_d  = row_bytes_q;
        row_stride_d = row_stride_q;
        wd_cnt_d     = wd_cnt_q;
        num_rows_d   = num_rows_q;
        rows_done_d  = rows_done_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        dma_start_d  = dma_start_q;
        abort_d      = abort_q;

        case (state_q)
            S_IDLE: begin
                // IDLE spans two cycles per job: the accept cycle latches the
                // config and raises busy, the following cycle (busy already
                // high, so cfg_start is ignored) validates the latched job.
                // This places both the first dma_start and the early done
                // pulse two edges after the accepting edge.
                if (!busy_q) begin
                    if (cfg_start) begin
                        cur_addr_d   = cfg_base_addr;
                        num_rows_d   = cfg_num_rows;
                        row_bytes_d  = cfg_row_bytes;
                        row_stride_d = cfg_row_stride;
                        error_d      = 1'b0;
                        rows_done_d  = 16'd0;
                        abort_d      = 1'b0;
                        busy_d       = 1'b1;
                    end
                end else if (num_rows_q == 16'd0) begin
                    state_d = S_FINISH;
                end else if (row_len_bad) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Address/length load on the same edge dma_start rises, so
                // they are stable for the whole request.
                start_addr_d = cur_addr_q;
                xfer_len_d   = row_bytes_q;
                dma_start_d  = 1'b1;
                wd_cnt_d     = 32'd0;
                state_d      = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                if (dma.dma_done) begin
                    dma_start_d = 1'b0;
                    state_d     = S_RELEASE;
                    if (dma.dma_error) begin
                        error_d = 1'b1;
                        abort_d = 1'b1;
                    end else begin
                        rows_done_d = rows_done_q + 16'd1;
                        // Stride is zero-extended; wrap-around is intentional.
                        cur_addr_d  = cur_addr_q + AXI_ADDR_WIDTH'(row_stride_q);
                    end
                end else if (WD_ENABLE && (wd_cnt_q == WD_LAST)) begin
                    // DMA hung: give up on the job without a release phase.
                    error_d     = 1'b1;
                    dma_start_d = 1'b0;
                    state_d     = S_FINISH;
                end else if (WD_ENABLE) begin
                    wd_cnt_d = wd_cnt_q + 32'd1;
                end
            end

            S_RELEASE: begin
                // Wait for the DMA to drop done so the next row's request is
                // never mistaken for a completion of this one.
                if (!dma.dma_done) begin
                    if (abort_q || (rows_done_q == num_rows_q)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            start_addr_q <= '0;
            xfer_len_q   <= '0;
            row_bytes_q  <= '0;
            row_stride_q <= '0;
            wd_cnt_q     <= '0;
            num_rows_q   <= '0;
            rows_done_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            dma_start_q  <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            start_addr_q <= start_addr_d;
            xfer_len_q   <= xfer_len_d;
            row_bytes_q  <= row_bytes_d;
            row_stride_q <= row_stride_d;
            wd_cnt_q     <= wd_cnt_d;
            num_rows_q   <= num_rows_d;
            rows_done_q  <= rows_done_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            dma_start_q  <= dma_start_d;
            abort_q      <= abort_d;
        end
    end

    assign busy                    = busy_q;
    assign done                    = done_q;
    assign error                   = error_q;
    assign rows_done               = rows_done_q;
    assign dma.dma_start_addr      = start_addr_q;
    assign dma.dma_transfer_length = xfer_len_q;
    assign dma.dma_start           = dma_start_q;
endmodule

// File: tb/tb_wdma_row_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wdma_row_scheduler
// Self-checking bench: a DMA responder model answers dma_start after a
// configurable latency (optionally with an error on a chosen row), a monitor
// records every request, and each test compares against expectations worked
// out from the job rules (address = base + n*stride mod 2^64, etc.).
// A second instance with an 8-cycle watchdog and a silent DMA covers the
// timeout path.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wdma_row_scheduler;
    localparam int AW         = 64;
    localparam int JOB_BUDGET = 600;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [AW-1:0] cfg_base_addr;
    logic [15:0]   cfg_num_rows;
    logic [31:0]   cfg_row_bytes;
    logic [31:0]   cfg_row_stride;
    logic          cfg_start;
    logic          cfg_start_wd;
    logic          busy, done, error;
    logic [15:0]   rows_done;
    logic          busy_w, done_w, error_w;
    logic [15:0]   rows_done_w;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    wdma_row_scheduler_if #(.AXI_ADDR_WIDTH(AW)) dma_if ();
    wdma_row_scheduler_if #(.AXI_ADDR_WIDTH(AW)) wd_if ();

    assign wd_if.dma_done  = 1'b0;
    assign wd_if.dma_error = 1'b0;

    wdma_row_scheduler #(.AXI_ADDR_WIDTH(AW), .BEAT_BYTES(16), .TIMEOUT_CYCLES(65535)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_base_addr(cfg_base_addr), .cfg_num_rows(cfg_num_rows),
        .cfg_row_bytes(cfg_row_bytes), .cfg_row_stride(cfg_row_stride),
        .cfg_start(cfg_start),
        .busy(busy), .done(done), .error(error), .rows_done(rows_done),
        .dma(dma_if)
    );

    wdma_row_scheduler #(.AXI_ADDR_WIDTH(AW), .BEAT_BYTES(16), .TIMEOUT_CYCLES(8)) dut_wd (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_base_addr(cfg_base_addr), .cfg_num_rows(cfg_num_rows),
        .cfg_row_bytes(cfg_row_bytes), .cfg_row_stride(cfg_row_stride),
        .cfg_start(cfg_start_wd),
        .busy(busy_w), .done(done_w), .error(error_w), .rows_done(rows_done_w),
        .dma(wd_if)
    );

    // ---------------- DMA responder model ----------------
    int dma_lat     = 10;
    int dma_err_row = -1;
    int dma_row_idx = 0;
    int dma_cnt     = 0;
    bit dma_prev_start = 1'b0;

    always @(negedge aclk) begin
        if (!aresetn || !dma_if.dma_start) begin
            dma_cnt          = 0;
            dma_if.dma_done  = 1'b0;
            dma_if.dma_error = 1'b0;
        end else begin
            if (!dma_prev_start) dma_row_idx++;
            if (!dma_if.dma_done) begin
                dma_cnt++;
                if (dma_cnt >= dma_lat) begin
                    dma_if.dma_done  = 1'b1;
                    dma_if.dma_error = ((dma_row_idx - 1) == dma_err_row);
                end
            end
        end
        dma_prev_start = aresetn && dma_if.dma_start;
    end

    // ---------------- monitor ----------------
    logic [AW-1:0] q_addr[$];
    logic [31:0]   q_len[$];
    int            done_cnt    = 0;
    int            stab_viol   = 0;
    int            done_hi_viol = 0;
    logic          mon_prev_start = 1'b0;
    logic [AW-1:0] mon_prev_addr  = '0;
    logic [31:0]   mon_prev_len   = '0;

    always @(negedge aclk) begin
        if (dma_if.dma_start && !mon_prev_start) begin
            q_addr.push_back(dma_if.dma_start_addr);
            q_len.push_back(dma_if.dma_transfer_length);
        end
        if (dma_if.dma_start && mon_prev_start &&
            ((dma_if.dma_start_addr !== mon_prev_addr) ||
             (dma_if.dma_transfer_length !== mon_prev_len)))
            stab_viol++;
        if (done === 1'b1) done_cnt++;
        if ((done === 1'b1) && (dma_if.dma_done === 1'b1)) done_hi_viol++;
        mon_prev_start = dma_if.dma_start;
        mon_prev_addr  = dma_if.dma_start_addr;
        mon_prev_len   = dma_if.dma_transfer_length;
    end

    // ---------------- stimulus ----------------
    // Runs one job on the main instance. k counts negedges after the edge
    // that samples cfg_start. extra_k re-pulses cfg_start with a different
    // config mid-job; stop_k returns early (no wait for done).
    task automatic run_job(input logic [AW-1:0] base, input logic [15:0] rows,
                           input logic [31:0] rb, input logic [31:0] st,
                           input int lat, input int err_row,
                           input int extra_k, input int stop_k,
                           output int start_k, output int done_k);
        int k;
        @(negedge aclk);
        q_addr.delete();
        q_len.delete();
        done_cnt = 0; stab_viol = 0; done_hi_viol = 0;
        dma_lat = lat; dma_err_row = err_row; dma_row_idx = 0;
        cfg_base_addr = base; cfg_num_rows = rows;
        cfg_row_bytes = rb; cfg_row_stride = st;
        cfg_start = 1'b1;
        start_k = -1; done_k = -1; k = 0;
        while (k < JOB_BUDGET) begin
            @(negedge aclk);
            k++;
            if (k == 1 || k == extra_k + 1) cfg_start = 1'b0;
            if (k == extra_k) begin
                cfg_start      = 1'b1;
                cfg_base_addr  = ~base;
                cfg_num_rows   = rows + 16'd7;
                cfg_row_bytes  = rb + 32'd16;
                cfg_row_stride = st ^ 32'h1234_5670;
            end
            if (start_k < 0 && dma_if.dma_start === 1'b1) start_k = k;
            if (done === 1'b1) begin done_k = k; break; end
            if (k == stop_k) break;
        end
        cfg_start = 1'b0;
        if (done_k >= 0) repeat (3) @(negedge aclk);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        cfg_start = 1'b0; cfg_start_wd = 1'b0;
        cfg_base_addr = '0; cfg_num_rows = '0; cfg_row_bytes = '0; cfg_row_stride = '0;
        repeat (3) @(negedge aclk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b expected 0", error); end
        checks++; if (rows_done !== 16'd0) begin failures++; $display("FAIL reset_rows_done: got %0d expected 0", rows_done); end
        checks++; if (dma_if.dma_start !== 1'b0) begin failures++; $display("FAIL reset_dma_start: got %b expected 0", dma_if.dma_start); end
        checks++; if (dma_if.dma_start_addr !== '0) begin failures++; $display("FAIL reset_addr: got %0h expected 0", dma_if.dma_start_addr); end
        checks++; if (dma_if.dma_transfer_length !== 32'd0) begin failures++; $display("FAIL reset_len: got %0h expected 0", dma_if.dma_transfer_length); end
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_basic();
        int sk, dk;
        logic [AW-1:0] exp_addr[3];
        exp_addr[0] = 64'h1000; exp_addr[1] = 64'h1100; exp_addr[2] = 64'h1200;
        run_job(64'h1000, 16'd3, 32'd64, 32'd256, 10, -1, -1, -1, sk, dk);
        checks++; if (q_addr.size() !== 3) begin failures++; $display("FAIL basic_num_starts: got %0d expected 3", q_addr.size()); end
        for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
            checks++; if (q_addr[i] !== exp_addr[i]) begin failures++; $display("FAIL basic_addr%0d: got %0h expected %0h", i, q_addr[i], exp_addr[i]); end
            checks++; if (q_len[i] !== 32'd64) begin failures++; $display("FAIL basic_len%0d: got %0d expected 64", i, q_len[i]); end
        end
        checks++; if (sk !== 3) begin failures++; $display("FAIL basic_start_latency: got k=%0d expected k=3", sk); end
        checks++; if (dk < 0) begin failures++; $display("FAIL basic_done_seen: got none expected a pulse"); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        checks++; if (rows_done !== 16'd3) begin failures++; $display("FAIL basic_rows_done: got %0d expected 3", rows_done); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL basic_error: got %b expected 0", error); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
        checks++; if (stab_viol !== 0) begin failures++; $display("FAIL basic_stable: got %0d changes expected 0", stab_viol); end
    endtask

    task automatic test_empty_and_bad();
        int sk, dk;
        logic [15:0] rows_t[2];
        logic [31:0] rb_t[2];
        logic        err_t[2];
        rows_t[0] = 16'd0; rb_t[0] = 32'd64; err_t[0] = 1'b0;
        rows_t[1] = 16'd4; rb_t[1] = 32'd24; err_t[1] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            run_job(64'h4000, rows_t[t], rb_t[t], 32'h100, 5, -1, -1, -1, sk, dk);
            checks++; if (q_addr.size() !== 0) begin failures++; $display("FAIL empty_bad%0d_starts: got %0d expected 0", t, q_addr.size()); end
            // done high in the second cycle after the cfg_start cycle
            checks++; if (dk !== 3) begin failures++; $display("FAIL empty_bad%0d_done_latency: got k=%0d expected k=3", t, dk); end
            checks++; if (done_cnt !== 1) begin failures++; $display("FAIL empty_bad%0d_done_count: got %0d expected 1", t, done_cnt); end
            checks++; if (error !== err_t[t]) begin failures++; $display("FAIL empty_bad%0d_error: got %b expected %b", t, error, err_t[t]); end
            checks++; if (rows_done !== 16'd0) begin failures++; $display("FAIL empty_bad%0d_rows_done: got %0d expected 0", t, rows_done); end
        end
    endtask

    task automatic test_dma_error();
        int sk, dk;
        logic [AW-1:0] base;
        logic [31:0]   st;
        base = {$urandom, $urandom} & ~64'hF;
        st   = $urandom;
        run_job(base, 16'd4, 32'd16 * $urandom_range(1, 8), st, $urandom_range(2, 8), 1, -1, -1, sk, dk);
        checks++; if (q_addr.size() !== 2) begin failures++; $display("FAIL dmaerr_num_starts: got %0d expected 2", q_addr.size()); end
        if (q_addr.size() >= 2) begin
            checks++; if (q_addr[1] !== base + 64'(st)) begin failures++; $display("FAIL dmaerr_addr1: got %0h expected %0h", q_addr[1], base + 64'(st)); end
        end
        checks++; if (rows_done !== 16'd1) begin failures++; $display("FAIL dmaerr_rows_done: got %0d expected 1", rows_done); end
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL dmaerr_error: got %b expected 1", error); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL dmaerr_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_hi_viol !== 0) begin failures++; $display("FAIL dmaerr_done_before_release: got %0d expected 0", done_hi_viol); end
    endtask

    task automatic test_timeout();
        int k, hi, dk;
        @(negedge aclk);
        cfg_base_addr = 64'h8000; cfg_num_rows = 16'd2;
        cfg_row_bytes = 32'd32;   cfg_row_stride = 32'h40;
        cfg_start_wd  = 1'b1;
        k = 0; hi = 0; dk = -1;
        while (k < 100) begin
            @(negedge aclk);
            k++;
            if (k == 1) cfg_start_wd = 1'b0;
            if (wd_if.dma_start === 1'b1) hi++;
            if (done_w === 1'b1) begin dk = k; break; end
        end
        cfg_start_wd = 1'b0;
        @(negedge aclk);
        checks++; if (hi !== 8) begin failures++; $display("FAIL timeout_start_cycles: got %0d expected 8", hi); end
        checks++; if (dk < 0 || dk > 14) begin failures++; $display("FAIL timeout_done: got k=%0d expected done within 14", dk); end
        checks++; if (error_w !== 1'b1) begin failures++; $display("FAIL timeout_error: got %b expected 1", error_w); end
        checks++; if (rows_done_w !== 16'd0) begin failures++; $display("FAIL timeout_rows_done: got %0d expected 0", rows_done_w); end
        checks++; if (busy_w !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %b expected 0", busy_w); end
    endtask

    task automatic test_busy_ignore();
        int sk, dk;
        logic [AW-1:0] base;
        base = 64'h0000_1234_0000_0000;
        run_job(base, 16'd3, 32'd48, 32'h40, 6, -1, 5, -1, sk, dk);
        checks++; if (q_addr.size() !== 3) begin failures++; $display("FAIL busy_num_starts: got %0d expected 3", q_addr.size()); end
        for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
            checks++; if (q_addr[i] !== base + 64'(i) * 64'h40) begin failures++; $display("FAIL busy_addr%0d: got %0h expected %0h", i, q_addr[i], base + 64'(i) * 64'h40); end
            checks++; if (q_len[i] !== 32'd48) begin failures++; $display("FAIL busy_len%0d: got %0d expected 48", i, q_len[i]); end
        end
        checks++; if (rows_done !== 16'd3) begin failures++; $display("FAIL busy_rows_done: got %0d expected 3", rows_done); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL busy_error: got %b expected 0", error); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL busy_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_midjob();
        int sk, dk;
        run_job(64'h2000, 16'd3, 32'd64, 32'h100, 10, -1, -1, 6, sk, dk);
        checks++; if (dma_if.dma_start !== 1'b1) begin failures++; $display("FAIL rst_mid_precond: got dma_start=%b expected 1", dma_if.dma_start); end
        #2 aresetn = 1'b0;
        #1;
        checks++; if ({busy, done, error, dma_if.dma_start} !== 4'b0) begin failures++; $display("FAIL rst_mid_flags: got %b expected 0000", {busy, done, error, dma_if.dma_start}); end
        checks++; if (dma_if.dma_start_addr !== '0 || dma_if.dma_transfer_length !== 32'd0 || rows_done !== 16'd0) begin
            failures++; $display("FAIL rst_mid_values: got addr=%0h len=%0h rows=%0d expected 0", dma_if.dma_start_addr, dma_if.dma_transfer_length, rows_done); end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (4) @(negedge aclk);
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_cnt); end
        run_job(64'hFFFF_FFFF_FFFF_FF00, 16'd2, 32'd32, 32'h100, 5, -1, -1, -1, sk, dk);
        checks++; if (q_addr.size() !== 2) begin failures++; $display("FAIL wrap_num_starts: got %0d expected 2", q_addr.size()); end
        if (q_addr.size() == 2) begin
            checks++; if (q_addr[0] !== 64'hFFFF_FFFF_FFFF_FF00) begin failures++; $display("FAIL wrap_addr0: got %0h expected ffffffffffffff00", q_addr[0]); end
            checks++; if (q_addr[1] !== 64'h0) begin failures++; $display("FAIL wrap_addr1: got %0h expected 0", q_addr[1]); end
        end
        checks++; if (rows_done !== 16'd2 || error !== 1'b0) begin failures++; $display("FAIL wrap_status: got rows=%0d err=%b expected rows=2 err=0", rows_done, error); end
    endtask

    task automatic test_random();
        int sk, dk, mode, lat, err_row, e_n;
        logic [AW-1:0] base, ea;
        logic [15:0]   rows, e_rows_done;
        logic [31:0]   rb, st;
        bit            bad, e_err;
        for (int it = 0; it < 20; it++) begin
            mode = $urandom_range(0, 9);
            rows = 16'($urandom_range(0, 5));
            if (mode == 0)      rb = 32'd0;
            else if (mode == 1) rb = 32'd16 * $urandom_range(0, 8) + 32'($urandom_range(1, 15));
            else                rb = 32'd16 * $urandom_range(1, 16);
            base    = {$urandom, $urandom};
            st      = $urandom;
            lat     = $urandom_range(1, 12);
            err_row = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1;
            // reference: rows==0 wins, then row length check, then DMA errors
            bad = (rb == 0) || (rb % 16 != 0);
            if (rows == 0)      begin e_n = 0; e_err = 0; e_rows_done = 0; end
            else if (bad)       begin e_n = 0; e_err = 1; e_rows_done = 0; end
            else if (err_row >= 0 && err_row < int'(rows)) begin e_n = err_row + 1; e_err = 1; e_rows_done = 16'(err_row); end
            else                begin e_n = rows; e_err = 0; e_rows_done = rows; end
            run_job(base, rows, rb, st, lat, err_row, -1, -1, sk, dk);
            checks++; if (q_addr.size() !== e_n) begin failures++; $display("FAIL rand%0d_num_starts: got %0d expected %0d", it, q_addr.size(), e_n); end
            for (int i = 0; i < e_n && i < q_addr.size(); i++) begin
                ea = base + 64'(i) * 64'(st);
                checks++; if (q_addr[i] !== ea || q_len[i] !== rb) begin failures++; $display("FAIL rand%0d_row%0d: got %0h/%0d expected %0h/%0d", it, i, q_addr[i], q_len[i], ea, rb); end
            end
            checks++; if (rows_done !== e_rows_done) begin failures++; $display("FAIL rand%0d_rows_done: got %0d expected %0d", it, rows_done, e_rows_done); end
            checks++; if (error !== e_err) begin failures++; $display("FAIL rand%0d_error: got %b expected %b", it, error, e_err); end
            checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rand%0d_done_count: got %0d expected 1", it, done_cnt); end
            checks++; if (sk !== ((e_n > 0) ? 3 : -1)) begin failures++; $display("FAIL rand%0d_start_latency: got k=%0d expected k=%0d", it, sk, (e_n > 0) ? 3 : -1); end
            checks++; if (stab_viol !== 0) begin failures++; $display("FAIL rand%0d_stable: got %0d changes expected 0", it, stab_viol); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_and_bad();
        test_dma_error();
        test_timeout();
        test_busy_ignore();
        test_reset_midjob();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global time limit reached");
    end
endmodule
